// File: rtl/blackjack_pkg.sv
// Shared types and constants for the blackjack table: round states, outcomes,
// command codes from the command stage, and card helpers.
package blackjack_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEAL_P1,
        ST_DEAL_D1,
        ST_DEAL_P2,
        ST_DEAL_D2,
        ST_PLAYER_TURN,
        ST_PLAYER_DRAW,
        ST_DEALER_TURN,
        ST_DEALER_DRAW,
        ST_RESULT
    } round_state_t;

    typedef enum logic [2:0] {
        OUT_NONE      = 3'd0,
        OUT_WIN       = 3'd1,
        OUT_LOSE      = 3'd2,
        OUT_PUSH      = 3'd3,
        OUT_BLACKJACK = 3'd4
    } outcome_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_HIT   = 2'd1,
        CMD_STAND = 2'd2
    } gameCommand;

    localparam int BLACKJACK_TOTAL = 21;
    localparam int ACE_RANK        = 1;
    localparam int FACE_VALUE      = 10;
    localparam int RANK_MAX        = 13;

    function automatic logic rank_is_valid(input logic [3:0] rank);
        return (rank >= 4'(ACE_RANK)) && (rank <= 4'(RANK_MAX));
    endfunction

    // Aces count 1 here; the soft +10 is applied when the effective total is formed.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank > 4'(FACE_VALUE)) ? 4'(FACE_VALUE) : rank;
    endfunction

endpackage

// File: rtl/hand_accumulator.sv
// One blackjack hand: running hard total, ace flag and the derived effective total.
module hand_accumulator
    import blackjack_pkg::*;
#(
    parameter int TOTAL_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_add,
    input  logic [3:0]         i_rank,
    output logic [TOTAL_W-1:0] o_hardTotal,
    output logic               o_aceFlag,
    output logic [TOTAL_W-1:0] o_effectiveTotal
);

    // NOTE: non-blocking assignments so both registers update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hardTotal <= '0;
            o_aceFlag   <= 1'b0;
        end else if (i_clear) begin
            o_hardTotal <= '0;
            o_aceFlag   <= 1'b0;
        end else if (i_add) begin
            o_hardTotal <= o_hardTotal + TOTAL_W'(card_value(i_rank));
            if (i_rank == 4'(ACE_RANK)) begin
                o_aceFlag <= 1'b1;
            end
        end
    end

    // One ace may count as 11 as long as that does not push the hand past 21.
    assign o_effectiveTotal =
        (o_aceFlag && (o_hardTotal <= TOTAL_W'(BLACKJACK_TOTAL - FACE_VALUE)))
            ? o_hardTotal + TOTAL_W'(FACE_VALUE)
            : o_hardTotal;

endmodule

// File: rtl/round_controller.sv
// Blackjack round sequencer: deals, runs player and dealer turns over the deck
// handshake, and settles the round outcome.
module round_controller
    import blackjack_pkg::*;
#(
    parameter int DEALER_STAND = 17,
    parameter int TOTAL_W      = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_dealButtonPushed,
    input  logic               i_ready,
    input  gameCommand         i_command,
    output logic               o_turnIndicator,
    output logic               o_cardReq,
    input  logic               i_cardValid,
    input  logic [3:0]         i_cardRank,
    output logic [TOTAL_W-1:0] o_playerTotal,
    output logic [TOTAL_W-1:0] o_dealerTotal,
    output logic [2:0]         o_outcome,
    output logic               o_roundDone
);

    round_state_t       state_q, state_d;
    outcome_t           outcome_q, outcome_d;
    logic [TOTAL_W-1:0] upcard_q, upcard_d;
    logic               reveal_q, reveal_d;

    logic               hand_clear, player_add, dealer_add;
    logic [TOTAL_W-1:0] player_hard, player_eff, dealer_hard, dealer_eff;
    logic               player_ace, dealer_ace;
    logic [TOTAL_W-1:0] player_next_eff, dealer_next_eff;
    logic               card_state, card_accept;

    // Effective total the hand would have once the presented card is added.
    function automatic logic [TOTAL_W-1:0] eff_with_card(
        input logic [TOTAL_W-1:0] hard,
        input logic               ace,
        input logic [3:0]         rank
    );
        logic [TOTAL_W-1:0] new_hard;
        logic               new_ace;
        new_hard = hard + TOTAL_W'(card_value(rank));
        new_ace  = ace || (rank == 4'(ACE_RANK));
        return (new_ace && (new_hard <= TOTAL_W'(BLACKJACK_TOTAL - FACE_VALUE)))
            ? new_hard + TOTAL_W'(FACE_VALUE) : new_hard;
    endfunction

    function automatic outcome_t settle(
        input logic [TOTAL_W-1:0] player,
        input logic [TOTAL_W-1:0] dealer
    );
        if (dealer > TOTAL_W'(BLACKJACK_TOTAL)) return OUT_WIN;
        if (player > dealer)                    return OUT_WIN;
        if (player < dealer)                    return OUT_LOSE;
        return OUT_PUSH;
    endfunction

    hand_accumulator #(.TOTAL_W(TOTAL_W)) u_player_hand (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_clear          (hand_clear),
        .i_add            (player_add),
        .i_rank           (i_cardRank),
        .o_hardTotal      (player_hard),
        .o_aceFlag        (player_ace),
        .o_effectiveTotal (player_eff)
    );

    hand_accumulator #(.TOTAL_W(TOTAL_W)) u_dealer_hand (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_clear          (hand_clear),
        .i_add            (dealer_add),
        .i_rank           (i_cardRank),
        .o_hardTotal      (dealer_hard),
        .o_aceFlag        (dealer_ace),
        .o_effectiveTotal (dealer_eff)
    );

    assign player_next_eff = eff_with_card(player_hard, player_ace, i_cardRank);
    assign dealer_next_eff = eff_with_card(dealer_hard, dealer_ace, i_cardRank);

    assign card_state  = (state_q == ST_DEAL_P1) || (state_q == ST_DEAL_D1) ||
                         (state_q == ST_DEAL_P2) || (state_q == ST_DEAL_D2) ||
                         (state_q == ST_PLAYER_DRAW) || (state_q == ST_DEALER_DRAW);
    assign card_accept = card_state && i_cardValid && rank_is_valid(i_cardRank);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            outcome_q <= OUT_NONE;
            upcard_q  <= '0;
            reveal_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            outcome_q <= outcome_d;
            upcard_q  <= upcard_d;
            reveal_q  <= reveal_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no branch can infer a latch.
        state_d    = state_q;
        outcome_d  = outcome_q;
        upcard_d   = upcard_q;
        reveal_d   = reveal_q;
        hand_clear = 1'b0;
        player_add = 1'b0;
        dealer_add = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_RESULT: begin
                if (i_dealButtonPushed) begin
                    state_d    = ST_DEAL_P1;
                    outcome_d  = OUT_NONE;
                    upcard_d   = '0;
                    reveal_d   = 1'b0;
                    hand_clear = 1'b1;
                end
            end
            ST_DEAL_P1: begin
                if (card_accept) begin
                    player_add = 1'b1;
                    state_d    = ST_DEAL_D1;
                end
            end
            ST_DEAL_D1: begin
                if (card_accept) begin
                    dealer_add = 1'b1;
                    upcard_d   = dealer_next_eff;
                    state_d    = ST_DEAL_P2;
                end
            end
            ST_DEAL_P2: begin
                if (card_accept) begin
                    player_add = 1'b1;
                    state_d    = ST_DEAL_D2;
                end
            end
            ST_DEAL_D2: begin
                if (card_accept) begin
                    dealer_add = 1'b1;
                    if (player_eff == TOTAL_W'(BLACKJACK_TOTAL)) begin
                        state_d   = ST_RESULT;
                        outcome_d = (dealer_next_eff == TOTAL_W'(BLACKJACK_TOTAL))
                                    ? OUT_PUSH : OUT_BLACKJACK;
                    end else begin
                        state_d = ST_PLAYER_TURN;
                    end
                end
            end
            ST_PLAYER_TURN: begin
                if (i_ready) begin
                    case (i_command)
                        CMD_HIT:   state_d = ST_PLAYER_DRAW;
                        CMD_STAND: begin
                            state_d  = ST_DEALER_TURN;
                            reveal_d = 1'b1;
                        end
                        default:   state_d = ST_PLAYER_TURN;
                    endcase
                end
            end
            ST_PLAYER_DRAW: begin
                if (card_accept) begin
                    player_add = 1'b1;
                    if (player_next_eff > TOTAL_W'(BLACKJACK_TOTAL)) begin
                        state_d   = ST_RESULT;
                        outcome_d = OUT_LOSE;
                    end else if (player_next_eff == TOTAL_W'(BLACKJACK_TOTAL)) begin
                        state_d  = ST_DEALER_TURN;
                        reveal_d = 1'b1;
                    end else begin
                        state_d = ST_PLAYER_TURN;
                    end
                end
            end
            ST_DEALER_TURN: begin
                if (dealer_eff < TOTAL_W'(DEALER_STAND)) begin
                    state_d = ST_DEALER_DRAW;
                end else begin
                    state_d   = ST_RESULT;
                    outcome_d = settle(player_eff, dealer_eff);
                end
            end
            ST_DEALER_DRAW: begin
                if (card_accept) begin
                    dealer_add = 1'b1;
                    state_d    = ST_DEALER_TURN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_turnIndicator = (state_q == ST_PLAYER_TURN);
    assign o_cardReq       = card_state;
    assign o_roundDone     = (state_q == ST_RESULT);
    assign o_playerTotal   = player_eff;
    // The hole card stays hidden until the dealer actually plays.
    assign o_dealerTotal   = reveal_q ? dealer_eff : upcard_q;
    assign o_outcome       = outcome_q;

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: scripted rounds with pinned results,
// then randomized play, all compared every cycle against a card-list model.
module tb_round_controller;
    import blackjack_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_dealButtonPushed = 1'b0;
    logic       i_ready = 1'b0;
    gameCommand i_command = CMD_NONE;
    logic       i_cardValid = 1'b0;
    logic [3:0] i_cardRank = 4'd0;
    logic       o_turnIndicator, o_cardReq, o_roundDone;
    logic [4:0] o_playerTotal, o_dealerTotal;
    logic [2:0] o_outcome;

    round_controller #(.DEALER_STAND(17), .TOTAL_W(5)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_dealButtonPushed (i_dealButtonPushed),
        .i_ready            (i_ready),
        .i_command          (i_command),
        .o_turnIndicator    (o_turnIndicator),
        .o_cardReq          (o_cardReq),
        .i_cardValid        (i_cardValid),
        .i_cardRank         (i_cardRank),
        .o_playerTotal      (o_playerTotal),
        .o_dealerTotal      (o_dealerTotal),
        .o_outcome          (o_outcome),
        .o_roundDone        (o_roundDone)
    );

    always #5 i_clk = ~i_clk;

    localparam int M_IDLE = 0, M_DEAL = 1, M_PTURN = 2, M_PDRAW = 3,
                   M_DTURN = 4, M_DDRAW = 5, M_RESULT = 6;
    localparam int O_NONE = 0, O_WIN = 1, O_LOSE = 2, O_PUSH = 3, O_BJ = 4;

    int  n_cmp = 0;
    int  n_fail = 0;
    int  n_req = 0;
    int  deck_q[$];
    bit  rnd = 1'b0;
    bit  req_s = 1'b0, turn_s = 1'b0, done_s = 1'b0;

    // Model: hands as plain card lists, round position as a coarse phase.
    int  pc[$];
    int  dc[$];
    int  m_phase = M_IDLE;
    int  m_k = 0;
    int  m_outcome = O_NONE;
    bit  m_reveal = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int card_at(bit dealer, int idx);
        return dealer ? dc[idx] : pc[idx];
    endfunction

    // Best total of the first n cards: one ace counts 11 if that does not bust.
    function automatic int eff_of(bit dealer, int n);
        int hard = 0;
        bit ace = 1'b0;
        for (int i = 0; i < n; i++) begin
            int r = card_at(dealer, i);
            hard += (r > 10) ? 10 : r;
            if (r == 1) ace = 1'b1;
        end
        return (ace && hard + 10 <= 21) ? hard + 10 : hard;
    endfunction

    function automatic bit model_wants_card();
        return (m_phase == M_DEAL) || (m_phase == M_PDRAW) || (m_phase == M_DDRAW);
    endfunction

    task automatic model_step();
        int  r = int'(i_cardRank);
        bit  acc = model_wants_card() && i_cardValid && (r >= 1) && (r <= 13);
        int  p;
        int  d;
        case (m_phase)
            M_IDLE, M_RESULT: if (i_dealButtonPushed) begin
                pc.delete(); dc.delete();
                m_outcome = O_NONE; m_reveal = 1'b0; m_k = 0; m_phase = M_DEAL;
            end
            M_DEAL: if (acc) begin
                if (m_k % 2 == 0) pc.push_back(r); else dc.push_back(r);
                m_k++;
                if (m_k == 4) begin
                    p = eff_of(0, pc.size());
                    d = eff_of(1, dc.size());
                    if (p == 21) begin
                        m_phase = M_RESULT;
                        m_outcome = (d == 21) ? O_PUSH : O_BJ;
                    end else begin
                        m_phase = M_PTURN;
                    end
                end
            end
            M_PTURN: if (i_ready) begin
                if (i_command == CMD_HIT) m_phase = M_PDRAW;
                else if (i_command == CMD_STAND) begin m_phase = M_DTURN; m_reveal = 1'b1; end
            end
            M_PDRAW: if (acc) begin
                pc.push_back(r);
                p = eff_of(0, pc.size());
                if (p > 21) begin m_phase = M_RESULT; m_outcome = O_LOSE; end
                else if (p == 21) begin m_phase = M_DTURN; m_reveal = 1'b1; end
                else m_phase = M_PTURN;
            end
            M_DTURN: begin
                p = eff_of(0, pc.size());
                d = eff_of(1, dc.size());
                if (d < 17) m_phase = M_DDRAW;
                else begin
                    m_phase = M_RESULT;
                    m_outcome = (d > 21) ? O_WIN : (p > d) ? O_WIN : (p < d) ? O_LOSE : O_PUSH;
                end
            end
            M_DDRAW: if (acc) begin dc.push_back(r); m_phase = M_DTURN; end
            default: ;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge i_clk or negedge i_rst_n);
            if (!i_rst_n) begin
                pc.delete(); dc.delete();
                m_phase = M_IDLE; m_k = 0; m_outcome = O_NONE; m_reveal = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge i_clk);
            req_s  = o_cardReq;
            turn_s = o_turnIndicator;
            done_s = o_roundDone;
            if (req_s) n_req++;
            check("cardReq", o_cardReq, model_wants_card());
            check("turnIndicator", o_turnIndicator, m_phase == M_PTURN);
            check("roundDone", o_roundDone, m_phase == M_RESULT);
            check("outcome", o_outcome, m_outcome);
            check("playerTotal", o_playerTotal, eff_of(0, pc.size()));
            check("dealerTotal", o_dealerTotal,
                  m_reveal ? eff_of(1, dc.size()) : eff_of(1, (dc.size() > 0) ? 1 : 0));
        end
    end

    function automatic int rand_item();
        int x = int'($urandom_range(0, 99));
        if (x < 10) return -1;
        if (x < 13) return 0;
        if (x < 15) return 14 + int'($urandom_range(0, 1));
        return int'($urandom_range(1, 13));
    endfunction

    // Deck: head item -1 is a stall cycle; invalid ranks are shown for one request cycle.
    initial begin
        forever begin
            int head;
            @(posedge i_clk);
            if (i_rst_n && req_s && deck_q.size() > 0) void'(deck_q.pop_front());
            #2;
            if (rnd && deck_q.size() == 0) deck_q.push_back(rand_item());
            if (deck_q.size() == 0) begin
                i_cardValid = 1'b0;
            end else begin
                head = deck_q[0];
                if (head < 0) begin
                    i_cardValid = 1'b0;
                    i_cardRank  = 4'($urandom_range(0, 15));
                end else begin
                    i_cardValid = 1'b1;
                    i_cardRank  = head[3:0];
                end
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic deal();
        i_dealButtonPushed = 1'b1;
        step();
        i_dealButtonPushed = 1'b0;
    endtask

    task automatic cmd(input gameCommand c);
        i_ready = 1'b1;
        i_command = c;
        step();
        i_ready = 1'b0;
        i_command = CMD_NONE;
    endtask

    task automatic wait_turn(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = turn_s;
        end
        if (!seen) check("wait_turn_timeout", 0, 1);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = done_s;
        end
        if (!seen) check("wait_done_timeout", 0, 1);
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        #2;
        check("rst_cardReq", o_cardReq, 0);
        check("rst_turn", o_turnIndicator, 0);
        check("rst_outcome", o_outcome, O_NONE);
        check("rst_done", o_roundDone, 0);
        check("rst_player", o_playerTotal, 0);
        i_rst_n = 1'b1;
        step();

        // Player blackjack
        deck_q = '{1, 9, 13, 7};
        deal();
        wait_done(50);
        check("bj_outcome", o_outcome, O_BJ);
        check("bj_player", o_playerTotal, 21);
        check("bj_dealer_up", o_dealerTotal, 9);
        n_req = 0;
        repeat (5) step();
        check("bj_no_req", n_req, 0);

        // Player bust; the dealer must not draw the spare card
        deck_q = '{10, 5, 6, 10, 9, 3};
        deal();
        wait_turn(50);
        cmd(CMD_HIT);
        wait_done(50);
        check("bust_outcome", o_outcome, O_LOSE);
        check("bust_player", o_playerTotal, 25);
        check("bust_dealer_up", o_dealerTotal, 5);
        check("bust_deck_left", deck_q.size(), 1);
        deck_q.delete();

        // Soft ace turns hard
        deck_q = '{1, 10, 6, 7, 10};
        deal();
        wait_turn(50);
        check("soft_player", o_playerTotal, 17);
        cmd(CMD_HIT);
        wait_turn(50);
        check("hard_player", o_playerTotal, 17);
        cmd(CMD_STAND);
        wait_done(50);
        check("soft_outcome", o_outcome, O_PUSH);
        check("soft_dealer", o_dealerTotal, 17);

        // Dealer draws to bust
        deck_q = '{10, 10, 9, 6, 10};
        deal();
        wait_turn(50);
        cmd(CMD_STAND);
        wait_done(50);
        check("dbust_outcome", o_outcome, O_WIN);
        check("dbust_dealer", o_dealerTotal, 26);
        check("dbust_player", o_playerTotal, 19);

        // Handshake stall, invalid rank, then one accepted 4
        deck_q = '{-1, -1, -1, -1, -1, 15, 4, 2, 10, 3, 10, 10};
        n_req = 0;
        deal();
        wait_turn(50);
        check("stall_req_cycles", n_req, 10);
        check("stall_player", o_playerTotal, 14);
        check("stall_dealer_up", o_dealerTotal, 2);
        cmd(CMD_STAND);
        wait_done(50);
        check("stall_outcome", o_outcome, O_WIN);
        check("stall_dealer", o_dealerTotal, 25);

        // Reset during a dealer draw with the request outstanding
        deck_q = '{10, 5, 8, 2};
        for (int i = 0; i < 30; i++) deck_q.push_back(-1);
        deal();
        wait_turn(50);
        cmd(CMD_STAND);
        step();
        step();
        check("mid_req", req_s, 1);
        check("mid_dealer", o_dealerTotal, 7);
        i_rst_n = 1'b0;
        deck_q.delete();
        #1;
        check("mid_rst_req", o_cardReq, 0);
        check("mid_rst_turn", o_turnIndicator, 0);
        check("mid_rst_player", o_playerTotal, 0);
        check("mid_rst_dealer", o_dealerTotal, 0);
        check("mid_rst_outcome", o_outcome, O_NONE);
        check("mid_rst_done", o_roundDone, 0);
        step();
        step();
        i_rst_n = 1'b1;
        step();
        deck_q = '{2, 3, 4, 5};
        deal();
        wait_turn(50);
        check("post_rst_player", o_playerTotal, 6);
        check("post_rst_dealer_up", o_dealerTotal, 3);
        deck_q.delete();

        // Randomized play: random deals, commands, deck stalls, invalid ranks, resets
        rnd = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            step();
            if ($urandom_range(0, 499) == 0) begin
                i_rst_n = 1'b0;
                step();
                i_rst_n = 1'b1;
            end
            i_dealButtonPushed = ($urandom_range(0, 5) == 0);
            i_ready            = ($urandom_range(0, 2) == 0);
            i_command          = gameCommand'($urandom_range(0, 2));
        end
        rnd = 1'b0;
        i_dealButtonPushed = 1'b0;
        i_ready = 1'b0;
        i_command = CMD_NONE;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
